display_scan_ctrl: RTL
======================

Name: display_scan_ctrl

Overview:
Time-multiplexed scan controller for the two-digit seven-segment display, feeding the 2:1 segment mux. It decodes two BCD digits into active-low segment patterns and drives the mux select and the active-low anode enables. A prescaled state machine inserts a blanking interval around every digit switch so no digit shows ghosting or a torn pattern. New digit values are double-buffered and committed once per frame.

Parameters:
REFRESH_DIV, 100000, clk cycles each digit is lit per scan slot (>=2; 1 ms at 100 MHz)
BLANK_CYC, 1000, clk cycles both anodes are off between slots (>=1 required for tear-free display)

Ports:
clk  input  1  system clock, all logic rising-edge
rst  input  1  synchronous active-high reset
bcd0  input  4  digit 0 value, shown when sel=0
bcd1  input  4  digit 1 value, shown when sel=1
load  input  1  1-cycle strobe; captures bcd0/bcd1 into shadow registers
seg_a  output  7  registered active-low pattern of digit 0, {g,f,e,d,c,b,a}; drives mux A
seg_b  output  7  registered active-low pattern of digit 1; drives mux B
sel  output  1  registered mux select; drives mux S
an  output  2  registered active-low anode enables; an[0]=digit 0, an[1]=digit 1
frame_tick  output  1  1-cycle pulse on each frame commit

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - state=BLK1, cnt=0.
  - shadow and active digit regs = 4'hF.
  - seg_a=seg_b=7'h7F, sel=0, an=2'b11, frame_tick=0.
  - rst held -> outputs stay at these values.
  - rst asserted mid-scan -> reset values on the very next cycle; shadow contents are lost.
- FSM states ON0 -> BLK0 -> ON1 -> BLK1 -> ON0 ...
  - ON0: an=10, sel=0
  - BLK0: an=11, sel=1
  - ON1: an=01, sel=1
  - BLK1: an=11, sel=0
  - sel changes on entry to a blank state, so the mux output settles before the next anode enables.
- Counter:
  - cnt increments each cycle and clears on every state change.
  - ON state exits when cnt==REFRESH_DIV-1; BLK state exits when cnt==BLANK_CYC-1.
  - Frame period = 2*(REFRESH_DIV+BLANK_CYC) cycles.
  - cnt width = clog2 of max(REFRESH_DIV, BLANK_CYC); no wrap outside the terminal compare.
- Load / commit:
  - load=1: shadow0<=bcd0, shadow1<=bcd1. Latest load before a commit wins.
  - Commit occurs on the ON1->BLK1 transition edge: active<=shadow, and frame_tick=1 for the first BLK1 cycle only.
  - Leaving BLK1 after reset is not a commit; no frame_tick.
  - load on the commit cycle: active takes the old shadow, shadow takes the new value, which shows one frame later.
- Decode, registered one cycle after active changes:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
  - A..F -> 7F (blank).
  - Pattern update always lands inside BLK1, while neither digit is lit.
- outputs are all registered, with no combinational input-to-output path.

Test Plan:
- Params REFRESH_DIV=4, BLANK_CYC=2; rst=1 for 3 cycles -> an=11, sel=0, seg_a=seg_b=7F, frame_tick=0 throughout.
- Release rst, no load -> an per cycle: 11,11, 10,10,10,10, 11,11, 01,01,01,01, 11,11, repeating (12-cycle period).
  - sel=1 exactly during BLK0+ON1.
  - frame_tick pulses in the first BLK1 cycle of each frame, not at the post-reset BLK1.
  - segs stay 7F.
- load with bcd0=3, bcd1=7 during ON0 -> seg_a/seg_b unchanged through ON1.
  - frame_tick at BLK1 entry; next cycle seg_a=30, seg_b=78.
  - Digit 0 first lit with 30 at the following ON0.
- load bcd0=4'hA, bcd1=8 -> after commit seg_a=7F, seg_b=00.
- load bcd0=5 in the same cycle as the ON1->BLK1 commit (previous shadow 3) -> this frame seg_a=30; after the next commit seg_a=12.
- rst pulsed during ON1 with digits showing 30/78 -> next cycle an=11, sel=0, segs=7F.
  - After release, scan restarts from BLK1 and segs stay 7F until a new load is committed.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: two-digit seven-segment scan controller with blanking and per-frame commit.
// Latency: outputs are registered. A committed digit shows on seg_a/seg_b one cycle after frame_tick.
// Backpressure: none. load is a fire-and-forget strobe, and the latest load before a commit wins.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   bcd0, bcd1      digit values captured into shadow registers on load
//   load            1-cycle capture strobe
//   seg_a, seg_b    active-low {g,f,e,d,c,b,a} patterns for digit 0 / digit 1 (mux A / mux B)
//   sel             mux select (0 = digit 0, 1 = digit 1)
//   an              active-low anode enables, an[0] = digit 0, an[1] = digit 1
//   frame_tick      1-cycle pulse in the first BLK1 cycle after each commit
module display_scan_ctrl #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] bcd0,
  input  logic [3:0] bcd1,
  input  logic       load,
  output logic [6:0] seg_a,
  output logic [6:0] seg_b,
  output logic       sel,
  output logic [1:0] an,
  output logic       frame_tick
);

  // The counter only has to reach the larger of the two terminal values.
  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(BLANK_CYC - 1);

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] DIGIT_OFF = 4'hF;

  typedef enum logic [1:0] {
    ST_ON0  = 2'd0,
    ST_BLK0 = 2'd1,
    ST_ON1  = 2'd2,
    ST_BLK1 = 2'd3
  } state_t;

  // Active-low segment decode. Non-decimal codes blank the digit.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       shadow0_q, shadow0_d;
  logic [3:0]       shadow1_q, shadow1_d;
  logic [3:0]       active0_q, active0_d;
  logic [3:0]       active1_q, active1_d;
  logic [6:0]       seg_a_q, seg_a_d;
  logic [6:0]       seg_b_q, seg_b_d;
  logic             sel_q, sel_d;
  logic [1:0]       an_q, an_d;
  logic             frame_tick_q, frame_tick_d;

  logic             slot_last;
  logic             commit;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CNT_W'(1);
    shadow0_d    = shadow0_q;
    shadow1_d    = shadow1_q;
    active0_d    = active0_q;
    active1_d    = active1_q;
    slot_last    = 1'b0;
    commit       = 1'b0;
    sel_d        = 1'b0;
    an_d         = 2'b11;

    // Terminal count depends on whether a digit is lit or the display is blanked.
    case (state_q)
      ST_ON0, ST_ON1: slot_last = (cnt_q == ON_LAST);
      default:        slot_last = (cnt_q == BLK_LAST);
    endcase

    if (slot_last) begin
      cnt_d = '0;
      case (state_q)
        ST_ON0:  state_d = ST_BLK0;
        ST_BLK0: state_d = ST_ON1;
        ST_ON1:  state_d = ST_BLK1;
        default: state_d = ST_ON0;
      endcase
    end

    // Frame commit happens when leaving ON1. The new patterns then land
    // inside BLK1, while both anodes are off.
    commit = slot_last && (state_q == ST_ON1);
    if (commit) begin
      active0_d = shadow0_q;
      active1_d = shadow1_q;
    end

    // A load on the commit cycle is not lost. It waits in the shadow
    // registers for the next frame.
    if (load) begin
      shadow0_d = bcd0;
      shadow1_d = bcd1;
    end

    seg_a_d      = bcd_to_seg(active0_q);
    seg_b_d      = bcd_to_seg(active1_q);
    frame_tick_d = commit;

    // Anode and select follow the next state, so the registered outputs line up
    // with the state register. sel flips on entry to a blank slot, which gives
    // the mux a full blank interval to settle before the next anode turns on.
    case (state_d)
      ST_ON0:  begin an_d = 2'b10; sel_d = 1'b0; end
      ST_BLK0: begin an_d = 2'b11; sel_d = 1'b1; end
      ST_ON1:  begin an_d = 2'b01; sel_d = 1'b1; end
      default: begin an_d = 2'b11; sel_d = 1'b0; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_BLK1;
      cnt_q        <= '0;
      shadow0_q    <= DIGIT_OFF;
      shadow1_q    <= DIGIT_OFF;
      active0_q    <= DIGIT_OFF;
      active1_q    <= DIGIT_OFF;
      seg_a_q      <= SEG_BLANK;
      seg_b_q      <= SEG_BLANK;
      sel_q        <= 1'b0;
      an_q         <= 2'b11;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shadow0_q    <= shadow0_d;
      shadow1_q    <= shadow1_d;
      active0_q    <= active0_d;
      active1_q    <= active1_d;
      seg_a_q      <= seg_a_d;
      seg_b_q      <= seg_b_d;
      sel_q        <= sel_d;
      an_q         <= an_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign seg_a      = seg_a_q;
  assign seg_b      = seg_b_q;
  assign sel        = sel_q;
  assign an         = an_q;
  assign frame_tick = frame_tick_q;

endmodule
